// File: rtl/tx_fifo_bi_multi.sv
// Bus-side register front end for NUM_CH transmit FIFOs: data push with overflow tracking,
// coherent 16-bit fill-level reads, flush control and a low-water interrupt.
module tx_fifo_bi_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                   busClk,
  input  logic                   rstSyncToBusClk,
  input  logic [2:0]             address,
  input  logic                   writeEn,
  input  logic                   strobe_i,
  input  logic [NUM_CH-1:0]      fifoSelect,
  input  logic [7:0]             busDataIn,
  output logic [7:0]             busDataOut,
  input  logic [16*NUM_CH-1:0]   numElementsInFifo,
  output logic [NUM_CH-1:0]      fifoWEn,
  output logic [7:0]             fifoWData,
  output logic [NUM_CH-1:0]      forceEmpty,
  output logic                   irq
);

  localparam int unsigned SelW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              r_strobe_prev;
  logic              r_armed;
  logic [NUM_CH-1:0] r_wen;
  logic [NUM_CH-1:0] r_force;
  logic [NUM_CH-1:0] r_ovf;
  logic [NUM_CH-1:0] r_irq_en;
  logic [7:0]        r_thr [NUM_CH];
  logic [7:0]        r_lo  [NUM_CH];
  logic [7:0]        r_wdata;
  logic [7:0]        r_rdata;
  logic              r_irq;

  logic              w_accept;
  logic              w_sel_valid;
  logic [SelW-1:0]   w_sel;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_low;
  logic [15:0]       w_cnt_sel;
  logic [7:0]        w_rd_val;

  // Lowest set bit of the select wins; scan from the top so the lowest overwrites last.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fifoSelect[i]) w_sel = SelW'(i);
    end
  end

  assign w_sel_valid = |fifoSelect;
  // r_armed blocks a strobe that was already high when reset released.
  assign w_accept    = strobe_i & ~r_strobe_prev & r_armed;
  assign w_cnt_sel   = numElementsInFifo[{w_sel, 4'b0000} +: 16];

  always_comb begin
    w_full = '0;
    w_low  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_full[i] = ({1'b0, numElementsInFifo[16*i +: 16]} + 17'(r_wen[i])) >= 17'(DEPTH);
      w_low[i]  = r_irq_en[i] & (numElementsInFifo[16*i +: 16] <= {8'h00, r_thr[i]})
                  & ~r_force[i];
    end
  end

  always_comb begin
    w_rd_val = 8'h00;
    if (w_sel_valid) begin
      case (address)
        3'd1:    w_rd_val = {5'b00000, r_irq_en[w_sel], r_ovf[w_sel], w_full[w_sel]};
        3'd2:    w_rd_val = w_cnt_sel[15:8];
        3'd3:    w_rd_val = r_lo[w_sel];
        3'd5:    w_rd_val = r_thr[w_sel];
        default: w_rd_val = 8'h00;
      endcase
    end
  end

  always_ff @(posedge busClk or posedge rstSyncToBusClk) begin
    if (rstSyncToBusClk) begin
      r_strobe_prev <= 1'b0;
      r_armed       <= 1'b0;
      r_wen         <= '0;
      r_force       <= '0;
      r_ovf         <= '0;
      r_irq_en      <= '0;
      r_wdata       <= 8'h00;
      r_rdata       <= 8'h00;
      r_irq         <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_thr[i] <= 8'h00;
        r_lo[i]  <= 8'h00;
      end
    end else begin
      r_strobe_prev <= strobe_i;
      if (!strobe_i) r_armed <= 1'b1;
      r_wen   <= '0;
      r_force <= '0;
      r_irq   <= |w_low;

      if (w_accept) begin
        if (writeEn) begin
          if (w_sel_valid) begin
            case (address)
              3'd0: begin
                if (w_full[w_sel]) begin
                  r_ovf[w_sel] <= 1'b1;
                end else begin
                  r_wen[w_sel] <= 1'b1;
                  r_wdata      <= busDataIn;
                end
              end
              3'd4: begin
                if (busDataIn[0]) r_force[w_sel] <= 1'b1;
                if (busDataIn[1]) r_ovf[w_sel]   <= 1'b0;
                r_irq_en[w_sel] <= busDataIn[2];
              end
              3'd5:    r_thr[w_sel] <= busDataIn;
              default: ;
            endcase
          end
        end else begin
          r_rdata <= w_rd_val;
          if (w_sel_valid && address == 3'd2) r_lo[w_sel] <= w_cnt_sel[7:0];
        end
      end

      // Flush pulse clears overflow; placed last so a clear beats a same-cycle set.
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_force[i]) r_ovf[i] <= 1'b0;
      end
    end
  end

  assign fifoWEn    = r_wen;
  assign fifoWData  = r_wdata;
  assign forceEmpty = r_force;
  assign busDataOut = r_rdata;
  assign irq        = r_irq;

endmodule

// File: tb/tb_tx_fifo_bi_multi.sv
// Directed bench for tx_fifo_bi_multi (NUM_CH=4, DEPTH=64); inputs driven and outputs
// sampled 1 time unit after the rising edge.
module tb_tx_fifo_bi_multi;

  localparam int unsigned NCh = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       address = 3'd0;
  logic             writeEn = 1'b0;
  logic             strobe = 1'b0;
  logic [NCh-1:0]   fifoSelect = '0;
  logic [7:0]       busDataIn = 8'h00;
  logic [7:0]       busDataOut;
  logic [16*NCh-1:0] nef;
  logic [NCh-1:0]   fifoWEn;
  logic [7:0]       fifoWData;
  logic [NCh-1:0]   forceEmpty;
  logic             irq;
  logic [15:0]      cnt [NCh];

  int total = 0;
  int bad   = 0;

  tx_fifo_bi_multi #(.NUM_CH(NCh), .DEPTH(64)) dut (
    .busClk            (clk),
    .rstSyncToBusClk   (rst),
    .address           (address),
    .writeEn           (writeEn),
    .strobe_i          (strobe),
    .fifoSelect        (fifoSelect),
    .busDataIn         (busDataIn),
    .busDataOut        (busDataOut),
    .numElementsInFifo (nef),
    .fifoWEn           (fifoWEn),
    .fifoWData         (fifoWData),
    .forceEmpty        (forceEmpty),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  always_comb begin
    nef = '0;
    for (int i = 0; i < NCh; i++) nef[16*i +: 16] = cnt[i];
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One low cycle, then one high cycle; returns 1 unit after the accepting edge.
  task automatic acc(input logic we, input logic [2:0] a, input logic [NCh-1:0] sel,
                     input logic [7:0] d);
    @(posedge clk);
    #1;
    strobe = 1'b1; writeEn = we; address = a; fifoSelect = sel; busDataIn = d;
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    total++; if (fifoWEn !== 4'b0000) begin bad++; $display("FAIL reset_wen got=%b want=0000", fifoWEn); end
    total++; if (forceEmpty !== 4'b0000) begin bad++; $display("FAIL reset_force got=%b want=0000", forceEmpty); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    total++; if (busDataOut !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", busDataOut); end
    total++; if (fifoWData !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h want=00", fifoWData); end
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write;
    cnt[1] = 16'd10;
    acc(1'b1, 3'd0, 4'b0010, 8'hA5);
    total++; if (fifoWEn !== 4'b0010) begin bad++; $display("FAIL wr_wen got=%b want=0010", fifoWEn); end
    total++; if (fifoWData !== 8'hA5) begin bad++; $display("FAIL wr_wdata got=%h want=a5", fifoWData); end
    idle(1);
    total++; if (fifoWEn !== 4'b0000) begin bad++; $display("FAIL wr_wen_one_cycle got=%b want=0000", fifoWEn); end
    acc(1'b1, 3'd0, 4'b0110, 8'h3C);
    total++; if (fifoWEn !== 4'b0010) begin bad++; $display("FAIL wr_lowest_sel got=%b want=0010", fifoWEn); end
    acc(1'b1, 3'd0, 4'b0000, 8'h77);
    total++; if (fifoWEn !== 4'b0000) begin bad++; $display("FAIL wr_nosel got=%b want=0000", fifoWEn); end
    total++; if (fifoWData !== 8'h3C) begin bad++; $display("FAIL wr_nosel_data got=%h want=3c", fifoWData); end
  endtask

  task automatic test_full;
    cnt[0] = 16'd63;
    acc(1'b1, 3'd0, 4'b0001, 8'h11);
    total++; if (fifoWEn !== 4'b0001) begin bad++; $display("FAIL full_first got=%b want=0001", fifoWEn); end
    cnt[0] = 16'd64;
    acc(1'b1, 3'd0, 4'b0001, 8'h22);
    total++; if (fifoWEn !== 4'b0000) begin bad++; $display("FAIL full_drop got=%b want=0000", fifoWEn); end
    total++; if (fifoWData !== 8'h11) begin bad++; $display("FAIL full_wdata got=%h want=11", fifoWData); end
    acc(1'b0, 3'd1, 4'b0001, 8'h00);
    total++; if (busDataOut !== 8'h03) begin bad++; $display("FAIL full_status got=%h want=03", busDataOut); end
    acc(1'b0, 3'd1, 4'b0010, 8'h00);
    total++; if (busDataOut !== 8'h00) begin bad++; $display("FAIL full_other_ch got=%h want=00", busDataOut); end
  endtask

  task automatic test_count;
    cnt[2] = 16'h1234;
    acc(1'b0, 3'd2, 4'b0100, 8'h00);
    total++; if (busDataOut !== 8'h12) begin bad++; $display("FAIL cnt_hi got=%h want=12", busDataOut); end
    cnt[2] = 16'h1300;
    acc(1'b0, 3'd3, 4'b0100, 8'h00);
    total++; if (busDataOut !== 8'h34) begin bad++; $display("FAIL cnt_lo_latched got=%h want=34", busDataOut); end
    idle(3);
    total++; if (busDataOut !== 8'h34) begin bad++; $display("FAIL cnt_hold got=%h want=34", busDataOut); end
    acc(1'b0, 3'd2, 4'b0000, 8'h00);
    total++; if (busDataOut !== 8'h00) begin bad++; $display("FAIL rd_nosel got=%h want=00", busDataOut); end
    acc(1'b0, 3'd2, 4'b0100, 8'h00);
    total++; if (busDataOut !== 8'h13) begin bad++; $display("FAIL cnt_hi2 got=%h want=13", busDataOut); end
  endtask

  task automatic test_force;
    cnt[3] = 16'd64;
    acc(1'b1, 3'd0, 4'b1000, 8'h99);
    total++; if (fifoWEn !== 4'b0000) begin bad++; $display("FAIL ovf3_drop got=%b want=0000", fifoWEn); end
    acc(1'b0, 3'd1, 4'b1000, 8'h00);
    total++; if (busDataOut !== 8'h03) begin bad++; $display("FAIL ovf3_status got=%h want=03", busDataOut); end
    acc(1'b1, 3'd4, 4'b1000, 8'h01);
    total++; if (forceEmpty !== 4'b1000) begin bad++; $display("FAIL force_pulse got=%b want=1000", forceEmpty); end
    idle(1);
    total++; if (forceEmpty !== 4'b0000) begin bad++; $display("FAIL force_one_cycle got=%b want=0000", forceEmpty); end
    cnt[3] = 16'd0;
    acc(1'b0, 3'd1, 4'b1000, 8'h00);
    total++; if (busDataOut !== 8'h00) begin bad++; $display("FAIL force_clr_ovf got=%h want=00", busDataOut); end
    acc(1'b0, 3'd1, 4'b0001, 8'h00);
    total++; if (busDataOut !== 8'h03) begin bad++; $display("FAIL ch0_untouched got=%h want=03", busDataOut); end
    acc(1'b1, 3'd4, 4'b0001, 8'h02);
    total++; if (forceEmpty !== 4'b0000) begin bad++; $display("FAIL clr_no_pulse got=%b want=0000", forceEmpty); end
    acc(1'b0, 3'd1, 4'b0001, 8'h00);
    total++; if (busDataOut !== 8'h01) begin bad++; $display("FAIL ovf_clr_bit got=%h want=01", busDataOut); end
  endtask

  task automatic test_irq;
    cnt[0] = 16'd9;
    acc(1'b1, 3'd5, 4'b0001, 8'h08);
    acc(1'b0, 3'd5, 4'b0001, 8'h00);
    total++; if (busDataOut !== 8'h08) begin bad++; $display("FAIL thr_read got=%h want=08", busDataOut); end
    acc(1'b1, 3'd4, 4'b0001, 8'h04);
    idle(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_above got=%b want=0", irq); end
    acc(1'b0, 3'd1, 4'b0001, 8'h00);
    total++; if (busDataOut !== 8'h04) begin bad++; $display("FAIL irqen_status got=%h want=04", busDataOut); end
    cnt[0] = 16'd8;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_latency got=%b want=0", irq); end
    idle(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_low got=%b want=1", irq); end
    acc(1'b1, 3'd4, 4'b0001, 8'h05);
    total++; if (forceEmpty !== 4'b0001) begin bad++; $display("FAIL irq_force got=%b want=0001", forceEmpty); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_pre_mask got=%b want=1", irq); end
    idle(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b want=0", irq); end
    idle(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_unmasked got=%b want=1", irq); end
    acc(1'b0, 3'd6, 4'b0001, 8'h00);
    total++; if (busDataOut !== 8'h00) begin bad++; $display("FAIL reserved_rd got=%h want=00", busDataOut); end
    acc(1'b1, 3'd4, 4'b0001, 8'h00);
    idle(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_disabled got=%b want=0", irq); end
  endtask

  task automatic test_hold_and_reset;
    int pulses;
    cnt[1] = 16'd10;
    idle(1);
    strobe = 1'b1; writeEn = 1'b1; address = 3'd0; fifoSelect = 4'b0010; busDataIn = 8'h5A;
    pulses = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (fifoWEn[1]) pulses++;
    end
    strobe = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL hold_pulses got=%0d want=1", pulses); end
    acc(1'b0, 3'd5, 4'b0001, 8'h00);
    total++; if (busDataOut !== 8'h08) begin bad++; $display("FAIL pre_rst_thr got=%h want=08", busDataOut); end
    idle(1);
    strobe = 1'b1; writeEn = 1'b1; address = 3'd0; fifoSelect = 4'b0010; busDataIn = 8'hC3;
    @(posedge clk);
    #1;
    total++; if (fifoWEn !== 4'b0010) begin bad++; $display("FAIL pre_rst_wen got=%b want=0010", fifoWEn); end
    #3 rst = 1'b1;
    #1;
    total++; if (fifoWEn !== 4'b0000) begin bad++; $display("FAIL rst_async_wen got=%b want=0000", fifoWEn); end
    total++; if (fifoWData !== 8'h00) begin bad++; $display("FAIL rst_async_wdata got=%h want=00", fifoWData); end
    total++; if (busDataOut !== 8'h00) begin bad++; $display("FAIL rst_async_rdata got=%h want=00", busDataOut); end
    total++; if (forceEmpty !== 4'b0000) begin bad++; $display("FAIL rst_async_force got=%b want=0000", forceEmpty); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_async_irq got=%b want=0", irq); end
    #2 rst = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (fifoWEn[1]) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_held_strobe got=%0d want=0", pulses); end
    strobe = 1'b0;
    idle(1);
    strobe = 1'b1;
    @(posedge clk);
    #1;
    total++; if (fifoWEn !== 4'b0010) begin bad++; $display("FAIL rst_rearm got=%b want=0010", fifoWEn); end
    total++; if (fifoWData !== 8'hC3) begin bad++; $display("FAIL rst_rearm_data got=%h want=c3", fifoWData); end
    strobe = 1'b0;
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < NCh; i++) cnt[i] = 16'd0;
    test_reset();
    test_write();
    test_full();
    test_count();
    test_force();
    test_irq();
    test_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
